bus_timer: RTL and testbench

//  Memory-mapped countdown timer that answers the CPU's load/store data-bus accesses.
//  The CPU core is the bus initiator; this block is a bus responder and sits behind the system bridge.
//  It is register-programmed, counts down from a preset value and raises an interrupt request on expiry.

---
 rtl/bus_timer_pkg.sv | 35 +++
 rtl/bus_timer_prescaler.sv | 37 +++
 rtl/bus_timer.sv | 163 ++++++++++++++++
 tb/tb_bus_timer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module : bus_timer_pkg
// Brief  : Shared definitions for the bus_timer block: FSM state encoding,
//          register word offsets, CTRL bit positions and MODE codes.
// Rev    : 1.0  initial release
// ============================================================================
package bus_timer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_PRESET   = 2'd1;
  localparam logic [1:0] ADDR_COUNT    = 2'd2;
  localparam logic [1:0] ADDR_PRESCALE = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Only code 01 reloads; the reserved codes behave as one-shot.
  function automatic logic is_reload(input logic [1:0] mode);
    return (mode == MODE_RELOAD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module : bus_timer_prescaler
// Brief  : Tick generator for bus_timer. Produces one tick every
//          prescale+1 cycles while advance is high; restart re-arms it.
//          Instantiated only when BUS_TIMER_PRESCALE_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module bus_timer_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  restart,
  input  logic                  advance,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;

  // >= rather than == so a PRESCALE lowered mid-count cannot strand the counter.
  assign tick = (cnt >= prescale);

  // Cycle counter between ticks; cleared on restart and after each tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= tick ? '0 : cnt + PRESCALE_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_timer.sv
`default_nettype none
// ============================================================================
// Module : bus_timer
// Brief  : Memory-mapped countdown timer on the CPU data bus. Counts down
//          from PRESET and raises a level interrupt on expiry. Optional
//          PRESCALE register is enabled by defining BUS_TIMER_PRESCALE_EN.
// Rev    : 1.0  initial release
// ============================================================================
module bus_timer #(
  parameter int COUNT_W    = 32,
  parameter int PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dev_sel,
  input  logic        dev_we,
  input  logic [1:0]  dev_addr,
  input  logic [31:0] dev_wdata,
  output logic [31:0] dev_rdata,
  output logic        irq_out
);
  import bus_timer_pkg::*;

  state_t               state, state_nx;
  logic                 ctrl_en;
  logic [1:0]           ctrl_mode;
  logic                 ctrl_im;
  logic [COUNT_W-1:0]   preset;
  logic [COUNT_W-1:0]   count, count_nx;
  logic [PRESCALE_W-1:0] prescale;
  logic                 irq_pend;
  logic                 wr_ctrl, wr_preset;
  logic                 set_pend, clr_pend, clr_en;
  logic                 tick;

  assign wr_ctrl   = dev_sel && dev_we && (dev_addr == ADDR_CTRL);
  assign wr_preset = dev_sel && dev_we && (dev_addr == ADDR_PRESET);
  assign irq_out   = ctrl_im && irq_pend;

`ifdef BUS_TIMER_PRESCALE_EN
  logic wr_prescale;
  assign wr_prescale = dev_sel && dev_we && (dev_addr == ADDR_PRESCALE);

  // PRESCALE register, programmed from the bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescale <= '0;
    end else if (wr_prescale) begin
      prescale <= dev_wdata[PRESCALE_W-1:0];
    end
  end

  bus_timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .restart  (state == S_LOAD),
    .advance  ((state == S_CNT) && ctrl_en),
    .prescale (prescale),
    .tick     (tick)
  );
`else
  // No prescaler: offset 3 is a read-as-zero hole and the count ticks every cycle.
  assign prescale = '0;
  assign tick     = 1'b1;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and countdown control.
  always_comb begin
    state_nx = state;
    count_nx = count;
    set_pend = 1'b0;
    clr_pend = 1'b0;
    clr_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (ctrl_en) state_nx = S_LOAD;
      end
      S_LOAD: begin
        count_nx = preset;
        clr_pend = 1'b1;
        state_nx = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_en) begin
          state_nx = S_IDLE;
        end else if (tick) begin
          if (count > COUNT_W'(1)) begin
            count_nx = count - COUNT_W'(1);
          end else begin
            count_nx = '0;
            set_pend = 1'b1;
            state_nx = S_INT;
          end
        end
      end
      S_INT: begin
        // Auto-reload keeps EN set so IDLE immediately re-enters LOAD.
        if (!is_reload(ctrl_mode)) clr_en = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Register file, count and pending flag; bus writes beat the FSM EN clear,
  // while an expiry beats the clear caused by a CTRL write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_en   <= 1'b0;
      ctrl_mode <= MODE_ONESHOT;
      ctrl_im   <= 1'b0;
      preset    <= '0;
      count     <= '0;
      irq_pend  <= 1'b0;
    end else begin
      count <= count_nx;
      if (wr_ctrl) begin
        ctrl_en   <= dev_wdata[CTRL_EN_BIT];
        ctrl_mode <= dev_wdata[CTRL_MODE_LSB +: 2];
        ctrl_im   <= dev_wdata[CTRL_IM_BIT];
      end else if (clr_en) begin
        ctrl_en <= 1'b0;
      end
      if (wr_preset) preset <= dev_wdata[COUNT_W-1:0];
      if (set_pend) begin
        irq_pend <= 1'b1;
      end else if (wr_ctrl || clr_pend) begin
        irq_pend <= 1'b0;
      end
    end
  end

  // Same-cycle read mux, zero-extended, and forced to 0 when not selected.
  always_comb begin
    dev_rdata = '0;
    if (dev_sel) begin
      case (dev_addr)
        ADDR_CTRL: begin
          dev_rdata[CTRL_EN_BIT]            = ctrl_en;
          dev_rdata[CTRL_MODE_LSB +: 2]     = ctrl_mode;
          dev_rdata[CTRL_IM_BIT]            = ctrl_im;
        end
        ADDR_PRESET:   dev_rdata[COUNT_W-1:0]    = preset;
        ADDR_COUNT:    dev_rdata[COUNT_W-1:0]    = count;
        ADDR_PRESCALE: dev_rdata[PRESCALE_W-1:0] = prescale;
        default:       dev_rdata = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_timer.sv
`default_nettype none
// ============================================================================
// Module : tb_bus_timer
// Brief  : Self-checking bench for bus_timer. Bus vectors with expected read
//          data / irq are queued, applied one per cycle and compared on the
//          falling edge; async reset is exercised by hand at the end.
//          Covers the BUS_TIMER_PRESCALE_EN build when that macro is defined.
// Rev    : 1.0  initial release
// ============================================================================
module tb_bus_timer;

  logic        clk;
  logic        reset;
  logic        dev_sel;
  logic        dev_we;
  logic [1:0]  dev_addr;
  logic [31:0] dev_wdata;
  logic [31:0] dev_rdata;
  logic        irq_out;

  int checks = 0;
  int errors = 0;

  bus_timer #(.COUNT_W(32), .PRESCALE_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .dev_sel   (dev_sel),
    .dev_we    (dev_we),
    .dev_addr  (dev_addr),
    .dev_wdata (dev_wdata),
    .dev_rdata (dev_rdata),
    .irq_out   (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] rd;
    logic        irq;
    logic        chk_pend;
    logic        pend;
  } vec_t;

  typedef struct {
    logic        chk_rd;
    logic [31:0] rd;
    logic        irq;
    logic        chk_pend;
    logic        pend;
    int          id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic w, input logic [1:0] a, input logic [31:0] d,
                     input logic cr, input logic [31:0] rd, input logic irq,
                     input logic cp, input logic pend);
    vec_t v;
    v.sel = s; v.we = w; v.addr = a; v.wdata = d;
    v.chk_rd = cr; v.rd = rd; v.irq = irq; v.chk_pend = cp; v.pend = pend;
    vecs.push_back(v);
  endtask

  task automatic rd_v(input logic [1:0] a, input logic [31:0] rd, input logic irq);
    add(1'b1, 1'b0, a, 32'h0, 1'b1, rd, irq, 1'b0, 1'b0);
  endtask

  task automatic rp_v(input logic [1:0] a, input logic [31:0] rd, input logic irq, input logic pend);
    add(1'b1, 1'b0, a, 32'h0, 1'b1, rd, irq, 1'b1, pend);
  endtask

  task automatic wr_v(input logic [1:0] a, input logic [31:0] d, input logic irq);
    add(1'b1, 1'b1, a, d, 1'b0, 32'h0, irq, 1'b0, 1'b0);
  endtask

  // Drive one vector for a cycle; expectation goes through the scoreboard.
  task automatic apply(input vec_t v, input int id);
    exp_t e;
    dev_sel = v.sel; dev_we = v.we; dev_addr = v.addr; dev_wdata = v.wdata;
    e.chk_rd = v.chk_rd; e.rd = v.rd; e.irq = v.irq;
    e.chk_pend = v.chk_pend; e.pend = v.pend; e.id = id;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      check("scoreboard_empty", id, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("irq_out", e.id, {31'd0, irq_out}, {31'd0, e.irq});
      if (e.chk_rd)   check("rdata", e.id, dev_rdata, e.rd);
      if (e.chk_pend) check("irq_pend", e.id, {31'd0, dut.irq_pend}, {31'd0, e.pend});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pre_cnt;
    reset = 1'b0; dev_sel = 1'b0; dev_we = 1'b0; dev_addr = 2'd0; dev_wdata = 32'h0;

    // Reset state: every register reads zero.
    for (int a = 0; a < 4; a++) rd_v(2'(a), 32'h0, 1'b0);

    // One-shot, PRESET=5, IM=1.
    wr_v(2'd1, 32'd5, 1'b0);
    wr_v(2'd0, 32'h9, 1'b0);
    rd_v(2'd2, 32'd0, 1'b0); rd_v(2'd2, 32'd0, 1'b0);
    rd_v(2'd2, 32'd5, 1'b0); rd_v(2'd2, 32'd4, 1'b0); rd_v(2'd2, 32'd3, 1'b0);
    rd_v(2'd2, 32'd2, 1'b0); rd_v(2'd2, 32'd1, 1'b0); rd_v(2'd2, 32'd0, 1'b1);
    rd_v(2'd0, 32'h8, 1'b1); rd_v(2'd1, 32'd5, 1'b1);
    wr_v(2'd0, 32'h8, 1'b1);
    rd_v(2'd0, 32'h8, 1'b0);

    // Auto-reload, PRESET=3: period of 6 cycles.
    wr_v(2'd1, 32'd3, 1'b0);
    wr_v(2'd0, 32'hB, 1'b0);
    for (int p = 0; p < 2; p++) begin
      if (p == 0) begin
        rd_v(2'd2, 32'd0, 1'b0); rd_v(2'd2, 32'd0, 1'b0);
      end
      rd_v(2'd2, 32'd3, 1'b0); rd_v(2'd2, 32'd2, 1'b0); rd_v(2'd2, 32'd1, 1'b0);
      rd_v(2'd2, 32'd0, 1'b1); rd_v(2'd2, 32'd0, 1'b1); rd_v(2'd2, 32'd0, 1'b1);
    end
    rd_v(2'd2, 32'd3, 1'b0);
    wr_v(2'd0, 32'h0, 1'b0);
    rd_v(2'd2, 32'd1, 1'b0); rd_v(2'd2, 32'd1, 1'b0);

    // EN cleared at COUNT=2, COUNT write ignored, re-enable reloads.
    wr_v(2'd1, 32'd5, 1'b0);
    wr_v(2'd0, 32'h9, 1'b0);
    rd_v(2'd2, 32'd1, 1'b0); rd_v(2'd2, 32'd1, 1'b0);
    rd_v(2'd2, 32'd5, 1'b0); rd_v(2'd2, 32'd4, 1'b0);
    wr_v(2'd0, 32'h8, 1'b0);
    rd_v(2'd2, 32'd2, 1'b0); rd_v(2'd2, 32'd2, 1'b0);
    wr_v(2'd2, 32'h55, 1'b0);
    rd_v(2'd2, 32'd2, 1'b0);
    wr_v(2'd0, 32'h9, 1'b0);
    rd_v(2'd2, 32'd2, 1'b0); rd_v(2'd2, 32'd2, 1'b0); rd_v(2'd2, 32'd5, 1'b0);
    wr_v(2'd0, 32'h0, 1'b0);
    rd_v(2'd2, 32'd3, 1'b0); rd_v(2'd2, 32'd3, 1'b0);

    // PRESET=0 expires one cycle after LOAD; then IM=0 masks the pending flag.
    wr_v(2'd1, 32'd0, 1'b0);
    wr_v(2'd0, 32'h9, 1'b0);
    rd_v(2'd2, 32'd3, 1'b0); rd_v(2'd2, 32'd3, 1'b0);
    rd_v(2'd2, 32'd0, 1'b0); rd_v(2'd2, 32'd0, 1'b1);
    rd_v(2'd0, 32'h8, 1'b1);
    wr_v(2'd0, 32'h8, 1'b1);
    rd_v(2'd0, 32'h8, 1'b0);
    wr_v(2'd0, 32'h1, 1'b0);
    rd_v(2'd2, 32'd0, 1'b0); rd_v(2'd2, 32'd0, 1'b0);
    rp_v(2'd2, 32'd0, 1'b0, 1'b0); rp_v(2'd2, 32'd0, 1'b0, 1'b1);
    rp_v(2'd0, 32'h0, 1'b0, 1'b1);
    wr_v(2'd0, 32'h0, 1'b0);
    rp_v(2'd0, 32'h0, 1'b0, 1'b0);

    // CTRL write on the expiry edge (set wins), then on the INT edge (write wins).
    wr_v(2'd1, 32'd2, 1'b0);
    wr_v(2'd0, 32'h9, 1'b0);
    rd_v(2'd2, 32'd0, 1'b0); rd_v(2'd2, 32'd0, 1'b0); rd_v(2'd2, 32'd2, 1'b0);
    wr_v(2'd0, 32'h9, 1'b0);
    wr_v(2'd0, 32'h9, 1'b1);
    rd_v(2'd0, 32'h9, 1'b0);
    wr_v(2'd0, 32'h0, 1'b0);
    rd_v(2'd2, 32'd2, 1'b0); rd_v(2'd2, 32'd2, 1'b0);

`ifdef BUS_TIMER_PRESCALE_EN
    // PRESCALE=1, PRESET=2: expiry four cycles after LOAD instead of two.
    wr_v(2'd3, 32'd1, 1'b0);
    rd_v(2'd3, 32'd1, 1'b0);
    wr_v(2'd1, 32'd2, 1'b0);
    wr_v(2'd0, 32'h9, 1'b0);
    rd_v(2'd2, 32'd2, 1'b0); rd_v(2'd2, 32'd2, 1'b0); rd_v(2'd2, 32'd2, 1'b0);
    rd_v(2'd2, 32'd2, 1'b0); rd_v(2'd2, 32'd1, 1'b0); rd_v(2'd2, 32'd1, 1'b0);
    rd_v(2'd2, 32'd0, 1'b1);
    wr_v(2'd0, 32'h0, 1'b1);
    wr_v(2'd3, 32'd0, 1'b0);
    pre_cnt = 32'd0;
`else
    // Offset 3 is a read-as-zero hole without the prescaler.
    wr_v(2'd3, 32'hFF, 1'b0);
    rd_v(2'd3, 32'd0, 1'b0);
    pre_cnt = 32'd2;
`endif

    // Start a count that the async reset below interrupts.
    wr_v(2'd1, 32'd5, 1'b0);
    wr_v(2'd0, 32'h9, 1'b0);
    rd_v(2'd2, pre_cnt, 1'b0); rd_v(2'd2, pre_cnt, 1'b0);
    rd_v(2'd2, 32'd5, 1'b0); rd_v(2'd2, 32'd4, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Mid-count asynchronous reset: registers clear without a clock edge.
    dev_sel = 1'b1; dev_we = 1'b0; dev_addr = 2'd2;
    #1;
    check("count_before_reset", -1, dev_rdata, 32'd3);
    reset = 1'b0;
    #1;
    check("count_async_reset", -1, dev_rdata, 32'd0);
    dev_addr = 2'd0;
    #1;
    check("ctrl_async_reset", -1, dev_rdata, 32'd0);
    dev_addr = 2'd1;
    #1;
    check("preset_async_reset", -1, dev_rdata, 32'd0);
    check("irq_async_reset", -1, {31'd0, irq_out}, 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    dev_addr = 2'd2;
    #1;
    check("count_after_reset", -1, dev_rdata, 32'd0);
    dev_sel = 1'b0;
    #1;
    check("rdata_unselected", -1, dev_rdata, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
